// File: rtl/adc_chan_scan.sv
// adc_chan_scan: round-robin ADC channel scanner with settle window,
// stability-gated sampling and power-of-two averaging per channel.
//
// Ports:
//   CLOCK_50  in   single clock
//   reset     in   asynchronous active-high reset
//   adc_value in   12-bit conversion result (adc_clk domain)
//   chan      out  channel select to adcinterface
//   ch_value  out  averaged results, channel k in [12k+11:12k]
//   upd       out  one-cycle pulse, a channel value was written
//   upd_ch    out  channel written by the current upd
//   scan_done out  one-cycle pulse with upd for channel NUM_CH-1
//   stall_err out  sticky, a sample was forced by the stall limit
module adc_chan_scan #(
  parameter int NUM_CH        = 2,
  parameter int SETTLE_CYCLES = 15000,
  parameter int SAMPLE_GAP    = 64,
  parameter int AVG_LOG2      = 2,
  parameter int STALL_LIMIT   = 1024
) (
  input  logic                   CLOCK_50,
  input  logic                   reset,
  input  logic [11:0]            adc_value,
  output logic [2:0]             chan,
  output logic [12*NUM_CH-1:0]   ch_value,
  output logic                   upd,
  output logic [2:0]             upd_ch,
  output logic                   scan_done,
  output logic                   stall_err
);

  localparam int CMAX =
    (SETTLE_CYCLES > SAMPLE_GAP) ? SETTLE_CYCLES : SAMPLE_GAP;
  localparam int CW = $clog2(CMAX + 1);
  localparam int SW =
    (STALL_LIMIT > 1) ? $clog2(STALL_LIMIT) : 1;
  localparam int AW = 12 + AVG_LOG2;
  localparam int NW = AVG_LOG2 + 1;

  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST    = CW'(SAMPLE_GAP - 1);
  localparam logic [SW-1:0] STALL_LAST  = SW'(STALL_LIMIT - 1);
  localparam logic [NW-1:0] N_LAST      = NW'((1 << AVG_LOG2) - 1);
  localparam logic [2:0]    CH_LAST     = 3'(NUM_CH - 1);

  typedef enum logic [1:0] {
    ST_SWITCH,
    ST_SETTLE,
    ST_SAMPLE,
    ST_PUBLISH
  } state_e;

  state_e              state_q, state_d;
  logic [11:0]         s1_q, s2_q;
  logic [AW-1:0]       acc_q, acc_d;
  logic [NW-1:0]       n_q, n_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [SW-1:0]       stall_q, stall_d;
  logic [2:0]          chan_q, chan_d;
  logic [12*NUM_CH-1:0] ch_value_q, ch_value_d;
  logic                upd_q, upd_d;
  logic [2:0]          upd_ch_q, upd_ch_d;
  logic                scan_done_q, scan_done_d;
  logic                stall_err_q, stall_err_d;

  logic                stable;
  logic                accept;
  logic [AW-1:0]       avg_full;

  // Two-flop capture; equal consecutive words mean the adc_clk
  // domain value was not changing while it was captured.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= adc_value;
      s2_q <= s1_q;
    end
  end

  assign stable   = (s1_q == s2_q);
  assign accept   = stable || (stall_q == STALL_LAST);
  assign avg_full = acc_q >> AVG_LOG2;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q     <= ST_SWITCH;
      acc_q       <= '0;
      n_q         <= '0;
      cnt_q       <= '0;
      stall_q     <= '0;
      chan_q      <= '0;
      ch_value_q  <= '0;
      upd_q       <= 1'b0;
      upd_ch_q    <= '0;
      scan_done_q <= 1'b0;
      stall_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      n_q         <= n_d;
      cnt_q       <= cnt_d;
      stall_q     <= stall_d;
      chan_q      <= chan_d;
      ch_value_q  <= ch_value_d;
      upd_q       <= upd_d;
      upd_ch_q    <= upd_ch_d;
      scan_done_q <= scan_done_d;
      stall_err_q <= stall_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    n_d         = n_q;
    cnt_d       = cnt_q;
    stall_d     = stall_q;
    chan_d      = chan_q;
    ch_value_d  = ch_value_q;
    upd_d       = 1'b0;
    upd_ch_d    = upd_ch_q;
    scan_done_d = 1'b0;
    stall_err_d = stall_err_q;

    unique case (state_q)
      ST_SWITCH: begin
        acc_d   = '0;
        n_d     = '0;
        cnt_d   = '0;
        stall_d = '0;
        state_d = ST_SETTLE;
      end

      ST_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d   = '0;
          state_d = ST_SAMPLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_SAMPLE: begin
        if (cnt_q >= GAP_LAST) begin
          // Check cycle: an unstable check holds cnt so the next
          // cycle is checked again until stable or forced.
          if (accept) begin
            acc_d   = acc_q + AW'(s2_q);
            n_d     = n_q + NW'(1);
            cnt_d   = '0;
            stall_d = '0;
            if (!stable) begin
              stall_err_d = 1'b1;
            end
            if (n_q == N_LAST) begin
              state_d = ST_PUBLISH;
            end
          end else begin
            stall_d = stall_q + SW'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_PUBLISH: begin
        for (int k = 0; k < NUM_CH; k++) begin
          if (chan_q == 3'(k)) begin
            ch_value_d[12*k +: 12] = avg_full[11:0];
          end
        end
        upd_ch_d    = chan_q;
        upd_d       = 1'b1;
        scan_done_d = (chan_q == CH_LAST);
        chan_d      = (chan_q == CH_LAST) ? 3'd0 : chan_q + 3'd1;
        state_d     = ST_SWITCH;
      end

      default: begin
        state_d = ST_SWITCH;
      end
    endcase
  end

  assign chan      = chan_q;
  assign ch_value  = ch_value_q;
  assign upd       = upd_q;
  assign upd_ch    = upd_ch_q;
  assign scan_done = scan_done_q;
  assign stall_err = stall_err_q;

endmodule

// File: tb/tb_adc_chan_scan.sv
// tb_adc_chan_scan: directed bench for adc_chan_scan with a 2-channel
// and a 3-channel instance sharing clock, reset and ADC input.
module tb_adc_chan_scan;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] adc;

  logic [2:0]  chan2, chan3;
  logic [23:0] val2;
  logic [35:0] val3;
  logic        upd2, upd3;
  logic [2:0]  uch2, uch3;
  logic        done2, done3;
  logic        serr2, serr3;

  int n_cmp = 0;
  int n_bad = 0;
  bit tog   = 1'b0;

  always #5 clk = ~clk;

  adc_chan_scan #(
    .NUM_CH(2), .SETTLE_CYCLES(4), .SAMPLE_GAP(2),
    .AVG_LOG2(2), .STALL_LIMIT(8)
  ) u_dut (
    .CLOCK_50(clk), .reset(rst), .adc_value(adc),
    .chan(chan2), .ch_value(val2), .upd(upd2),
    .upd_ch(uch2), .scan_done(done2), .stall_err(serr2)
  );

  adc_chan_scan #(
    .NUM_CH(3), .SETTLE_CYCLES(4), .SAMPLE_GAP(2),
    .AVG_LOG2(2), .STALL_LIMIT(8)
  ) u_dut3 (
    .CLOCK_50(clk), .reset(rst), .adc_value(adc),
    .chan(chan3), .ch_value(val3), .upd(upd3),
    .upd_ch(uch3), .scan_done(done3), .stall_err(serr3)
  );

  task automatic expect_eq(input string tag,
                           input logic [31:0] got,
                           input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance n active edges; outputs are then sampled 1 time unit later.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (tog) adc = ~adc;
    end
  endtask

  task automatic release_rst();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int  k;
    bit  seen;

    rst = 1'b1;
    adc = 12'h600;
    #12;
    expect_eq("rst_chan",   32'(chan2), 0);
    expect_eq("rst_val",    32'(val2), 0);
    expect_eq("rst_upd",    32'(upd2), 0);
    expect_eq("rst_upd_ch", 32'(uch2), 0);
    expect_eq("rst_done",   32'(done2), 0);
    expect_eq("rst_serr",   32'(serr2), 0);

    // Constant input, channel period of 14 edges.
    release_rst();
    step(13);
    expect_eq("const_upd_e13", 32'(upd2), 0);
    step(1);
    expect_eq("const_upd_e14",  32'(upd2), 1);
    expect_eq("const_uch_e14",  32'(uch2), 0);
    expect_eq("const_ch0_e14",  32'(val2[11:0]), 'h600);
    expect_eq("const_chan_e14", 32'(chan2), 1);
    expect_eq("const_done_e14", 32'(done2), 0);
    expect_eq("w3_uch_e14",     32'(uch3), 0);
    expect_eq("w3_done_e14",    32'(done3), 0);
    step(1);
    expect_eq("const_upd_e15", 32'(upd2), 0);
    step(12);
    expect_eq("const_upd_e27", 32'(upd2), 0);
    step(1);
    expect_eq("const_upd_e28",  32'(upd2), 1);
    expect_eq("const_uch_e28",  32'(uch2), 1);
    expect_eq("const_done_e28", 32'(done2), 1);
    expect_eq("const_chan_e28", 32'(chan2), 0);
    expect_eq("const_ch1_e28",  32'(val2[23:12]), 'h600);
    expect_eq("w3_uch_e28",     32'(uch3), 1);
    expect_eq("w3_done_e28",    32'(done3), 0);
    expect_eq("w3_chan_e28",    32'(chan3), 2);

    // Truncating average on ch0: samples 0x100,0x101,0x101,0x103.
    adc = 12'h100;
    for (int j = 1; j <= 14; j++) begin
      step(1);
      if (j == 1) expect_eq("trunc_upd_e29", 32'(upd2), 0);
      adc = (j < 6)  ? 12'h100 :
            (j < 10) ? 12'h101 : 12'h103;
    end
    expect_eq("trunc_upd",  32'(upd2), 1);
    expect_eq("trunc_uch",  32'(uch2), 0);
    expect_eq("trunc_ch0",  32'(val2[11:0]), 'h101);
    expect_eq("trunc_ch1",  32'(val2[23:12]), 'h600);
    expect_eq("trunc_done", 32'(done2), 0);
    expect_eq("w3_uch_e42",  32'(uch3), 2);
    expect_eq("w3_done_e42", 32'(done3), 1);
    expect_eq("w3_chan_e42", 32'(chan3), 0);
    expect_eq("w3_ch2_e42",  32'(val3[35:24]), 'h101);

    // Settle exclusion on ch1: 0xFFF in SETTLE, 0x200 from SAMPLE.
    adc  = 12'hFFF;
    k    = 0;
    seen = 1'b0;
    while (!seen && k < 30) begin
      step(1);
      k++;
      if (k >= 5) adc = 12'h200;
      if (upd2) seen = 1'b1;
    end
    expect_eq("settle_seen", 32'(seen), 1);
    expect_eq("settle_edge", 32'(k), 15);
    expect_eq("settle_uch",  32'(uch2), 1);
    expect_eq("settle_ch1",  32'(val2[23:12]), 'h200);
    expect_eq("settle_done", 32'(done2), 1);
    expect_eq("settle_serr", 32'(serr2), 0);
    expect_eq("w3_upd_4th",  32'(upd3), 1);
    expect_eq("w3_uch_4th",  32'(uch3), 0);
    expect_eq("w3_done_4th", 32'(done3), 0);
    expect_eq("w3_chan_4th", 32'(chan3), 1);

    // Stall: input toggles every cycle, each sample forced.
    rst = 1'b1;
    #2;
    release_rst();
    adc = 12'h000;
    tog = 1'b1;
    step(13);
    expect_eq("stall_serr_e13", 32'(serr2), 0);
    step(1);
    expect_eq("stall_serr_e14", 32'(serr2), 1);
    step(27);
    expect_eq("stall_upd_e41", 32'(upd2), 0);
    step(1);
    expect_eq("stall_upd_e42", 32'(upd2), 1);
    expect_eq("stall_uch_e42", 32'(uch2), 0);
    expect_eq("stall_ch0_e42", 32'(val2[11:0]), 'h7FF);
    tog = 1'b0;
    adc = 12'h300;
    step(14);
    expect_eq("stable_upd_e56",  32'(upd2), 1);
    expect_eq("stable_ch1_e56",  32'(val2[23:12]), 'h300);
    expect_eq("stable_serr_e56", 32'(serr2), 1);
    step(14);
    expect_eq("stable_ch0_e70",  32'(val2[11:0]), 'h300);
    expect_eq("stable_serr_e70", 32'(serr2), 1);

    // Reset after two accepted ch1 samples, checked without an edge.
    step(9);
    rst = 1'b1;
    #1;
    expect_eq("mid_rst_chan", 32'(chan2), 0);
    expect_eq("mid_rst_val",  32'(val2), 0);
    expect_eq("mid_rst_serr", 32'(serr2), 0);
    expect_eq("mid_rst_upd",  32'(upd2), 0);
    expect_eq("mid_rst_val3", 32'(val3 == 36'd0), 1);
    #3;
    release_rst();
    adc = 12'h555;
    step(13);
    expect_eq("post_upd_e13", 32'(upd2), 0);
    step(1);
    expect_eq("post_upd_e14",  32'(upd2), 1);
    expect_eq("post_uch_e14",  32'(uch2), 0);
    expect_eq("post_ch0_e14",  32'(val2[11:0]), 'h555);
    expect_eq("post_ch1_e14",  32'(val2[23:12]), 0);
    expect_eq("post_chan_e14", 32'(chan2), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/adc_chan_scan.md
# adc_chan_scan

Round-robin scanner between `adcinterface` and the servo angle-update logic. It drives the ADC channel select and waits a settling time after each switch. It then takes a power-of-two number of stable samples and publishes the truncated average for each joystick channel with a one-cycle update strobe. This replaces free-running channel toggling, so downstream servo logic never sees a sample taken during a channel change.

## Interface
- `NUM_CH`, 2: channels scanned, 0..NUM_CH-1; legal 1..8.
- `SETTLE_CYCLES`, 15000: CLOCK_50 cycles ignored after a channel switch; ≥1.
- `SAMPLE_GAP`, 64: minimum cycles between accepted samples; ≥1.
- `AVG_LOG2`, 2: log2 of samples averaged per channel; 0..4.
- `STALL_LIMIT`, 1024: consecutive unstable checks before forced acceptance; ≥1.

Ports:
- `CLOCK_50` in 1: the single clock.
- `reset` in 1: asynchronous, active-high reset.
- `adc_value` in 12: conversion result from `adcinterface` (adc_clk domain).
- `chan` out 3: channel select to `adcinterface`.
- `ch_value` out 12*NUM_CH: averaged result; channel k occupies bits [12k+11:12k].
- `upd` out 1: one-cycle pulse; a new value has been written.
- `upd_ch` out 3: channel written by the current `upd`.
- `scan_done` out 1: one-cycle pulse with the `upd` for channel NUM_CH-1.
- `stall_err` out 1: sticky flag; a sample was forced through the stall limit.

## Operation
- Input capture: `adc_value` is registered twice every cycle into s1 and then s2. A sample is "stable" when s1 == s2.
- The FSM has four states: SWITCH, SETTLE, SAMPLE and PUBLISH.
- SWITCH (1 cycle):
  - acc <= 0, n <= 0, cnt <= 0, stall <= 0.
  - Next state: SETTLE.
- SETTLE:
  - cnt increments each cycle.
  - When cnt == SETTLE_CYCLES-1: cnt <= 0 and go to SAMPLE.
- SAMPLE, incrementing cnt each cycle:
  - A check happens on any cycle with cnt ≥ SAMPLE_GAP-1.
  - If stable at a check: acc += s2, n++, cnt <= 0, stall <= 0.
  - If unstable at a check: stall++ and cnt holds.
  - When stall == STALL_LIMIT-1 and the check is still unstable: accept s2 anyway as above and set `stall_err`.
  - When the accepted sample is number 2^AVG_LOG2: go to PUBLISH.
- PUBLISH (1 cycle):
  - The slice of `ch_value` selected by `chan` <= acc >> AVG_LOG2 (floor).
  - `upd_ch` <= `chan`.
  - `upd` <= 1, and `scan_done` <= (chan == NUM_CH-1).
  - `chan` <= (chan == NUM_CH-1) ? 0 : chan+1.
  - Next state: SWITCH.
- Widths:
  - acc is 12+AVG_LOG2 bits and cannot overflow.
  - The average always fits in 12 bits.
  - `chan` never holds a value ≥ NUM_CH.
- NUM_CH = 1: `chan` stays 0; each `upd` also carries `scan_done`.
- `stall_err` clears only on reset.

## Timing
- Reset values:
  - `chan` = 0, all `ch_value` = 0, `upd_ch` = 0.
  - `upd` = 0, `scan_done` = 0, `stall_err` = 0.
  - s1 = s2 = 0, FSM = SWITCH.
- All outputs are registered; there is no combinational path from input to output.
- `chan` changes on the same edge that raises `upd`. The next SETTLE window starts one cycle later.
- Period per channel with stable input: 2 + SETTLE_CYCLES + 2^AVG_LOG2·SAMPLE_GAP cycles.
- The first `upd` after reset deasserts lands on that same count of active edges.
- `upd` is high for exactly one cycle. `ch_value` and `upd_ch` are valid on that cycle and hold until the next write.
- The pipeline delay of s1/s2 is absorbed into SETTLE. Samples taken in SETTLE are never accumulated.
- Reset asserted at any point, including mid-SAMPLE or on the PUBLISH cycle:
  - All state returns to reset values immediately.
  - The partial accumulation is discarded.
  - Scanning restarts at channel 0.

## Test plan
Test parameters unless stated: NUM_CH=2, SETTLE_CYCLES=4, SAMPLE_GAP=2, AVG_LOG2=2, STALL_LIMIT=8. Channel period is 14 cycles.

- **Constant input:** `adc_value` = 0x600 constant; release reset.
  - `upd` on edge 14 with `upd_ch`=0 and ch0 = 0x600.
  - `chan` = 1 on that same edge.
  - Next `upd` on edge 28 with `upd_ch`=1 and `scan_done`=1.
  - `chan` returns to 0.
- **Truncating average:** feed 0x100, 0x101, 0x101, 0x103 to the four accepted samples of ch0 (sum 0x405).
  - ch0 = 0x101 (floor).
  - ch1 is unchanged until its own `upd`.
- **Settle exclusion:** drive 0xFFF during SETTLE, then 0x200 from the first SAMPLE cycle.
  - The published value is 0x200; 0xFFF never contributes.
- **Stall:** toggle `adc_value` between 0x000 and 0xFFF every cycle during SAMPLE.
  - Each sample is forced after 8 unstable checks.
  - `stall_err` rises on the first forced acceptance and stays 1 through later stable scans.
- **Wrap with NUM_CH=3:**
  - `chan` sequence 0,1,2,0.
  - `scan_done` pulses only with `upd_ch`=2.
- **Reset mid-operation:** assert `reset` after 2 accepted ch1 samples.
  - `chan`, all `ch_value` and `stall_err` go to 0 with no clock edge needed.
  - After release, the first `upd` is for ch0 at edge 14.
